// File: rtl/quiz_countdown_display_if.sv
// Player-selector <-> countdown/display connection for the 4-player quiz buzzer.
// The selector drives the master side; quiz_countdown_display is the slave.
interface quiz_countdown_display_if;
  logic       Timer_Start;
  logic [3:0] Player_Number;
  logic       TimerL;
  logic [6:0] Sec_Remain;
  logic [7:0] Seg;
  logic [3:0] Dig_Sel;
  logic       Warn_Beep;

  modport master (
    output Timer_Start, Player_Number,
    input  TimerL, Sec_Remain, Seg, Dig_Sel, Warn_Beep
  );

  modport slave (
    input  Timer_Start, Player_Number,
    output TimerL, Sec_Remain, Seg, Dig_Sel, Warn_Beep
  );
endinterface

// File: rtl/quiz_countdown_display.sv
// Quiz countdown timer with a 4-digit multiplexed 7-segment driver.
// Define COUNTDOWN_BEEP_EN to build the last-seconds warning beep; otherwise Warn_Beep is tied low.
module quiz_countdown_display #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int START_SEC = 9,
  parameter int SCAN_DIV  = 50_000
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  quiz_countdown_display_if.slave  bus
);

  localparam int PW = (CLK_HZ   > 1) ? $clog2(CLK_HZ)   : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {RUN, FROZEN, EXPIRED} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [6:0]    sec_remain;
  logic          timer_l;
  logic          start_q;

  // Countdown FSM. start_q delays Timer_Start by one cycle, so a freeze
  // sampled in the same cycle as a tick suppresses that tick.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= RUN;
      presc      <= '0;
      sec_remain <= 7'(START_SEC);
      timer_l    <= 1'b0;
      start_q    <= 1'b1;
    end else begin
      start_q <= bus.Timer_Start;
      case (state)
        RUN: begin
          if (!start_q) begin
            state <= FROZEN;
          end else if (presc == PW'(CLK_HZ - 1)) begin
            presc <= '0;
            if (sec_remain == 7'd1) begin
              sec_remain <= 7'd0;
              timer_l    <= 1'b1;
              state      <= EXPIRED;
            end else begin
              sec_remain <= sec_remain - 7'd1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        FROZEN:  state <= FROZEN;
        EXPIRED: state <= EXPIRED;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.Sec_Remain = sec_remain;
  assign bus.TimerL     = timer_l;

`ifdef COUNTDOWN_BEEP_EN
  assign bus.Warn_Beep = (state == RUN) && (sec_remain >= 7'd1) && (sec_remain <= 7'd3)
                         && (presc < PW'(CLK_HZ / 4));
`else
  assign bus.Warn_Beep = 1'b0;
`endif

  function automatic logic [6:0] seg_code(input logic [3:0] val);
    case (val)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  logic [SW-1:0] scan_cnt;
  logic [1:0]    dig_idx;
  logic [1:0]    idx_next;
  logic [3:0]    tens;
  logic [3:0]    units;
  logic [3:0]    digit_val;
  logic          digit_blank;

  assign tens  = 4'(sec_remain / 7'd10);
  assign units = 4'(sec_remain % 7'd10);

  // Content is chosen for the digit that will be enabled after this edge,
  // so segments and enables always switch together.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    idx_next    = (scan_cnt == SW'(SCAN_DIV - 1)) ? dig_idx + 2'd1 : dig_idx;
    digit_val   = 4'd0;
    digit_blank = 1'b1;
    case (idx_next)
      2'd0: begin
        digit_val   = units;
        digit_blank = 1'b0;
      end
      2'd1: begin
        digit_val   = tens;
        digit_blank = (tens == 4'd0);
      end
      2'd3: begin
        if (bus.Player_Number >= 4'd1 && bus.Player_Number <= 4'd4) begin
          digit_val   = bus.Player_Number;
          digit_blank = 1'b0;
        end
      end
      default: ;
    endcase
  end

  logic [7:0] seg;
  logic [3:0] dig_sel;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
      seg      <= 8'hFF;
      dig_sel  <= 4'b1110;
    end else begin
      scan_cnt <= (scan_cnt == SW'(SCAN_DIV - 1)) ? '0 : scan_cnt + SW'(1);
      dig_idx  <= idx_next;
      seg      <= {1'b1, digit_blank ? 7'b1111111 : seg_code(digit_val)};
      dig_sel  <= ~(4'b0001 << idx_next);
    end
  end

  assign bus.Seg     = seg;
  assign bus.Dig_Sel = dig_sel;

endmodule

// File: tb/tb_quiz_countdown_display.sv
// Scoreboard bench for quiz_countdown_display: two DUTs (START_SEC 9 and 12) share stimulus;
// expected outputs come from a closed-form tick-count model and are checked by a monitor.
module tb_quiz_countdown_display;

  localparam int CLK_HZ   = 10;
  localparam int SCAN_DIV = 4;
  localparam int NEVER    = 1 << 30;

  typedef struct {
    int         cyc;
    logic       timer_l;
    logic [6:0] sec;
    logic [7:0] seg;
    logic [3:0] dig;
    logic       beep;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ts = 1'b1;
  logic [3:0] player = 4'd0;

  int cyc_n = 0;
  int s_low = NEVER;
  int n_checks = 0;
  int n_pass = 0;

  snap_t q0[$];
  snap_t q1[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  quiz_countdown_display_if bus0 ();
  quiz_countdown_display_if bus1 ();

  assign bus0.Timer_Start   = ts;
  assign bus0.Player_Number = player;
  assign bus1.Timer_Start   = ts;
  assign bus1.Player_Number = player;

  quiz_countdown_display #(.CLK_HZ(CLK_HZ), .START_SEC(9), .SCAN_DIV(SCAN_DIV)) dut9 (
    .CLK(clk), .RSTn(rst_n), .bus(bus0)
  );
  quiz_countdown_display #(.CLK_HZ(CLK_HZ), .START_SEC(12), .SCAN_DIV(SCAN_DIV)) dut12 (
    .CLK(clk), .RSTn(rst_n), .bus(bus1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Seconds ticks taken by the end of edge cyc: one per CLK_HZ edges, none
  // after the edge at which the low Timer_Start sample (s_low) was registered.
  function automatic int ticks(input int start, input int cyc, input int sl);
    int lim = (cyc < sl) ? cyc : sl;
    int t   = lim / CLK_HZ;
    return (t > start) ? start : t;
  endfunction

  function automatic snap_t model(input int start, input int cyc, input int sl, input logic [3:0] plyr);
    snap_t s;
    int tk, sp, idx, lim;
    logic [6:0] pat;
    tk        = ticks(start, cyc, sl);
    s.cyc     = cyc;
    s.sec     = 7'(start - tk);
    s.timer_l = (tk == start);
    s.beep    = 1'b0;
    if (cyc == 0) begin
      s.seg = 8'hFF;
      s.dig = 4'b1110;
      return s;
    end
    sp  = start - ticks(start, cyc - 1, sl);
    idx = (cyc / SCAN_DIV) % 4;
    s.dig = ~(4'b0001 << idx);
    case (idx)
      0:       pat = seg_tab[sp % 10];
      1:       pat = (sp / 10 == 0) ? 7'b1111111 : seg_tab[sp / 10];
      3:       pat = (plyr >= 4'd1 && plyr <= 4'd4) ? seg_tab[plyr] : 7'b1111111;
      default: pat = 7'b1111111;
    endcase
    s.seg = {1'b1, pat};
`ifdef COUNTDOWN_BEEP_EN
    lim    = (cyc < sl) ? cyc : sl;
    s.beep = (tk < start) && (cyc <= sl) && (s.sec >= 7'd1) && (s.sec <= 7'd3)
             && ((lim % CLK_HZ) < CLK_HZ / 4);
`else
    lim = 0;
`endif
    return s;
  endfunction

  task automatic push_expect();
    q0.push_back(model(9,  cyc_n, s_low, player));
    q1.push_back(model(12, cyc_n, s_low, player));
  endtask

  task automatic compare(input string tag, input snap_t exp, input logic tl, input logic [6:0] sec,
                         input logic [7:0] seg, input logic [3:0] dig, input logic beep);
    string p;
    p = $sformatf("%s c%0d", tag, exp.cyc);
    check({p, " TimerL"},     32'(tl),   32'(exp.timer_l));
    check({p, " Sec_Remain"}, 32'(sec),  32'(exp.sec));
    check({p, " Seg"},        32'(seg),  32'(exp.seg));
    check({p, " Dig_Sel"},    32'(dig),  32'(exp.dig));
    check({p, " Warn_Beep"},  32'(beep), 32'(exp.beep));
  endtask

  // Monitor: the bench pushes one expectation per cycle just after the
  // active edge; it is compared at the following falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (q0.size() > 0)
        compare("s9", q0.pop_front(), bus0.TimerL, bus0.Sec_Remain, bus0.Seg, bus0.Dig_Sel, bus0.Warn_Beep);
      while (q1.size() > 0)
        compare("s12", q1.pop_front(), bus1.TimerL, bus1.Sec_Remain, bus1.Seg, bus1.Dig_Sel, bus1.Warn_Beep);
    end
  end

  // Reset asserted between edges must take effect at once; held one more edge.
  task automatic do_reset();
    @(posedge clk); #2;
    rst_n  = 1'b0;
    ts     = 1'b1;
    player = 4'($urandom_range(0, 7));
    cyc_n  = 0;
    s_low  = NEVER;
    push_expect();
    @(posedge clk); #2;
    push_expect();
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  // Drop Timer_Start after edge 'drop', raise it again after edge 'restore'.
  task automatic run(input int cycles, input int drop, input int restore, input int fixed_player);
    for (int c = 1; c <= cycles; c++) begin
      @(posedge clk); #1;
      cyc_n++;
      push_expect();
      player = (fixed_player >= 0) ? 4'(fixed_player) : 4'($urandom_range(0, 7));
      if (cyc_n == drop) begin
        ts    = 1'b0;
        s_low = cyc_n + 1;
      end
      if (cyc_n == restore) ts = 1'b1;
    end
  endtask

  initial begin
    int d;
    do_reset();
    run(140, 0, 0, -1);       // free run to expiry, then hold
    do_reset();
    run(60, 35, 45, 3);       // buzz-in; later return of Timer_Start is ignored
    do_reset();
    run(100, 88, 0, -1);      // freeze sampled on the final-tick cycle wins
    do_reset();
    run(100, 89, 0, -1);      // one cycle later the final tick is taken
    do_reset();
    run(50, 0, 0, -1);        // reset mid-run at Sec_Remain 4, then full countdown
    do_reset();
    run(100, 0, 0, -1);
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(1, 110);
      do_reset();
      run(130, d, d + $urandom_range(1, 15), -1);
    end
    @(negedge clk); #1;
    check("queue drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
